// File: rtl/hash_state_bank_pkg.sv
// Shared constants and FSM state type for the hash chaining-state bank.
package hash_state_bank_pkg;

    localparam int HSB_W_DEF      = 32;
    localparam int HSB_NWORDS_DEF = 8;

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } hsb_state_t;

endpackage

// File: rtl/hash_state_bank_word_acc.sv
// One chaining word: IV load, midstate load and modular accumulate, in that priority.
module hash_word_acc #(
    parameter int           W    = 32,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_iv,
    input  logic         ld_mid,
    input  logic [W-1:0] mid_word,
    input  logic         add_en,
    input  logic [W-1:0] add_word,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INIT;
        end else if (ld_iv) begin
            q <= INIT;
        end else if (ld_mid) begin
            q <= mid_word;
        end else if (add_en) begin
            q <= q + add_word;
        end
    end

endmodule

// File: rtl/hash_state_bank.sv
// Chaining-state bank for a Merkle-Damgard hash: accumulates compressor outputs into H0..Hn.
// Optional feature: define MIDSTATE_EN to save the state after the first block and restart from it.
//
// state   | meaning
// IDLE    | no message in progress, state holds IV
// RUN     | accepting compressor results
// OUT     | digest presented, waiting for consumer
module hash_state_bank
    import hash_state_bank_pkg::*;
#(
    parameter int                   W      = HSB_W_DEF,
    parameter int                   NWORDS = HSB_NWORDS_DEF,
    parameter logic [NWORDS*W-1:0]  IV     = SHA256_IV,
    parameter int                   CNTW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    input  logic [NWORDS*W-1:0]    acc_data,
    input  logic                   acc_last,
    output logic                   digest_valid,
    input  logic                   digest_ready,
    output logic [NWORDS*W-1:0]    digest_data,
    output logic [CNTW-1:0]        blk_cnt
`ifdef MIDSTATE_EN
    ,
    input  logic                   reload_mid
`endif
);

    hsb_state_t            state_q;
    logic                  reload_req;
    logic                  accept;
    logic                  hshake;
    logic                  ld_iv;
    logic                  ld_mid;
    logic [NWORDS*W-1:0]   mid_word;

`ifdef MIDSTATE_EN
    assign reload_req = reload_mid;
`else
    assign reload_req = 1'b0;
`endif

    assign acc_ready    = (state_q == ST_RUN);
    assign digest_valid = (state_q == ST_OUT);
    assign accept       = acc_valid && acc_ready && !init && !reload_req;
    assign hshake       = digest_valid && digest_ready && !init && !reload_req;
    assign ld_iv        = init || hshake;
    assign ld_mid       = reload_req && !init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            blk_cnt <= '0;
        end else if (init) begin
            state_q <= ST_RUN;
            blk_cnt <= '0;
        end else if (reload_req) begin
            state_q <= ST_RUN;
            blk_cnt <= CNTW'(1);
        end else if (accept) begin
            if (blk_cnt != '1) begin
                blk_cnt <= blk_cnt + CNTW'(1);
            end
            if (acc_last) begin
                state_q <= ST_OUT;
            end
        end else if (hshake) begin
            state_q <= ST_IDLE;
        end
    end

    // Words are packed H0 in the MSBs; each lane adds independently with no carry between lanes.
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        localparam int LSB = (NWORDS - 1 - i) * W;
        hash_word_acc #(
            .W    (W),
            .INIT (IV[LSB +: W])
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld_iv    (ld_iv),
            .ld_mid   (ld_mid),
            .mid_word (mid_word[LSB +: W]),
            .add_en   (accept),
            .add_word (acc_data[LSB +: W]),
            .q        (digest_data[LSB +: W])
        );
    end

`ifdef MIDSTATE_EN
    logic [NWORDS*W-1:0] mid_q;
    logic [NWORDS*W-1:0] acc_sum;

    for (genvar i = 0; i < NWORDS; i++) begin : g_sum
        localparam int LSB = (NWORDS - 1 - i) * W;
        assign acc_sum[LSB +: W] = digest_data[LSB +: W] + acc_data[LSB +: W];
    end

    // Snapshot the post-add state of the first block so reload_mid can skip recomputing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_q <= IV;
        end else if (accept && (blk_cnt == '0)) begin
            mid_q <= acc_sum;
        end
    end

    assign mid_word = mid_q;
`else
    assign mid_word = '0;
`endif

endmodule

// File: tb/tb_hash_state_bank.sv
// Randomized and directed bench for hash_state_bank against an array-based reference model.
module tb_hash_state_bank;
    import hash_state_bank_pkg::*;

    localparam int W  = 32;
    localparam int NW = 8;
    localparam int CW = 8;
    localparam int DW = NW * W;
    localparam logic [DW-1:0] IV_OV = {32'hffffffff, SHA256_IV[DW-W-1:0]};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          init = 1'b0;
    logic          acc_valid = 1'b0;
    logic          acc_last = 1'b0;
    logic          digest_ready = 1'b0;
    logic [DW-1:0] acc_data = '0;
`ifdef MIDSTATE_EN
    logic          reload_mid = 1'b0;
`endif

    logic          acc_ready    [2];
    logic          digest_valid [2];
    logic [DW-1:0] digest_data  [2];
    logic [CW-1:0] blk_cnt      [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hash_state_bank #(.W(W), .NWORDS(NW), .IV(SHA256_IV), .CNTW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready[0]),
        .acc_data     (acc_data),
        .acc_last     (acc_last),
        .digest_valid (digest_valid[0]),
        .digest_ready (digest_ready),
        .digest_data  (digest_data[0]),
        .blk_cnt      (blk_cnt[0])
`ifdef MIDSTATE_EN
        ,
        .reload_mid   (reload_mid)
`endif
    );

    hash_state_bank #(.W(W), .NWORDS(NW), .IV(IV_OV), .CNTW(CW)) dut_ov (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready[1]),
        .acc_data     (acc_data),
        .acc_last     (acc_last),
        .digest_valid (digest_valid[1]),
        .digest_ready (digest_ready),
        .digest_data  (digest_data[1]),
        .blk_cnt      (blk_cnt[1])
`ifdef MIDSTATE_EN
        ,
        .reload_mid   (reload_mid)
`endif
    );

    // Reference model: words as arrays, phase 0=idle 1=run 2=out.
    logic [W-1:0] m_iv  [2][NW];
    logic [W-1:0] m_h   [2][NW];
    logic [W-1:0] m_mid [2][NW];
    int           m_ph;
    int           m_blk;

    function automatic logic [W-1:0] in_word(int i);
        return acc_data[(NW-1-i)*W +: W];
    endfunction

    function automatic logic [DW-1:0] m_pack(int k);
        logic [DW-1:0] v;
        for (int i = 0; i < NW; i++) v[(NW-1-i)*W +: W] = m_h[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NW; i++) begin
                m_h[k][i]   = m_iv[k][i];
                m_mid[k][i] = m_iv[k][i];
            end
        m_ph  = 0;
        m_blk = 0;
    endtask

    task automatic model_step();
        bit reload = 1'b0;
`ifdef MIDSTATE_EN
        reload = reload_mid;
`endif
        if (init) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NW; i++) m_h[k][i] = m_iv[k][i];
            m_blk = 0;
            m_ph  = 1;
        end else if (reload) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NW; i++) m_h[k][i] = m_mid[k][i];
            m_blk = 1;
            m_ph  = 1;
        end else if (m_ph == 1 && acc_valid) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NW; i++) begin
                    m_h[k][i] = m_h[k][i] + in_word(i);
                    if (m_blk == 0) m_mid[k][i] = m_h[k][i];
                end
            if (m_blk < (1 << CW) - 1) m_blk++;
            if (acc_last) m_ph = 2;
        end else if (m_ph == 2 && digest_ready) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NW; i++) m_h[k][i] = m_iv[k][i];
            m_ph = 0;
        end
    endtask

    task automatic check_val(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 2; k++) begin
            check_val({tag, "/digest"}, digest_data[k], m_pack(k));
            check_val({tag, "/blk_cnt"}, DW'(blk_cnt[k]), DW'(m_blk));
            check_val({tag, "/acc_ready"}, DW'(acc_ready[k]), DW'(m_ph == 1));
            check_val({tag, "/digest_valid"}, DW'(digest_valid[k]), DW'(m_ph == 2));
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    logic [DW-1:0] hold;

    initial begin
        for (int i = 0; i < NW; i++) begin
            m_iv[0][i] = SHA256_IV[(NW-1-i)*W +: W];
            m_iv[1][i] = IV_OV[(NW-1-i)*W +: W];
        end
        model_reset();

        #2 rst_n = 1'b0;
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        tick("release");

        // Known SHA-256 "abc" final-add vector on H0
        init = 1'b1; tick("init");
        init = 1'b0; acc_valid = 1'b1; acc_last = 1'b1;
        acc_data = {32'h506e3058, 224'h0};
        tick("abc_acc");
        acc_valid = 1'b0; acc_last = 1'b0;
        check_val("abc_h0", DW'(digest_data[0][DW-1 -: W]), DW'(32'hba7816bf));
        check_val("abc_h1_7", DW'(digest_data[0][DW-W-1:0]), DW'(SHA256_IV[DW-W-1:0]));
        check_val("abc_valid", DW'(digest_valid[0]), DW'(1'b1));
        check_val("abc_blk", DW'(blk_cnt[0]), DW'(1));
        digest_ready = 1'b1; tick("abc_hs");
        digest_ready = 1'b0;

        // Modular wrap of H0 on the overridden-IV instance
        init = 1'b1; tick("wrap_init");
        init = 1'b0; acc_valid = 1'b1; acc_data = {32'h00000001, 224'h0};
        tick("wrap_acc");
        acc_valid = 1'b0;
        check_val("wrap_h0", DW'(digest_data[1][DW-1 -: W]), DW'(32'h0));
        check_val("wrap_h1", DW'(digest_data[1][DW-W-1 -: W]), DW'(32'hbb67ae85));

        // Second block with last, then digest held while consumer stalls
        acc_valid = 1'b1; acc_last = 1'b1; acc_data = rand_data();
        tick("hold_acc");
        acc_last = 1'b0;
        hold = digest_data[0];
        for (int c = 0; c < 5; c++) begin
            acc_valid = 1'($urandom_range(1));
            acc_data  = rand_data();
            tick("hold_cyc");
            check_val("out_stable", digest_data[0], hold);
        end
        acc_valid = 1'b0; digest_ready = 1'b1;
        tick("hold_hs");
        digest_ready = 1'b0;
        check_val("hs_state_iv", digest_data[0], SHA256_IV);
        check_val("hs_idle", DW'({acc_ready[0], digest_valid[0]}), DW'(2'b00));

        // init wins over a simultaneous accept
        init = 1'b1; tick("ia_init");
        init = 1'b0; acc_valid = 1'b1; acc_data = rand_data();
        tick("ia_acc");
        init = 1'b1; acc_data = rand_data();
        tick("ia_both");
        init = 1'b0; acc_valid = 1'b0;
        check_val("ia_state_iv", digest_data[0], SHA256_IV);
        check_val("ia_blk", DW'(blk_cnt[0]), DW'(0));

        // blk_cnt saturates at all-ones
        acc_valid = 1'b1; acc_last = 1'b0;
        for (int c = 0; c < 260; c++) begin
            acc_data = rand_data();
            tick("sat");
        end
        acc_valid = 1'b0;
        check_val("sat_blk", DW'(blk_cnt[0]), DW'(8'hff));

        // Asynchronous reset mid-message
        init = 1'b1; tick("ar_init");
        init = 1'b0; acc_valid = 1'b1; acc_data = rand_data();
        tick("ar_acc");
        acc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("ar_state_iv", digest_data[0], SHA256_IV);
        check_val("ar_ready", DW'(acc_ready[0]), DW'(1'b0));
        check_val("ar_blk", DW'(blk_cnt[0]), DW'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick("ar_release");

`ifdef MIDSTATE_EN
        begin
            logic [DW-1:0] blk2;
            logic [DW-1:0] d1;
            blk2 = rand_data();
            init = 1'b1; tick("mid_init");
            init = 1'b0; acc_valid = 1'b1; acc_data = rand_data();
            tick("mid_b1");
            acc_data = blk2; acc_last = 1'b1;
            tick("mid_b2");
            acc_valid = 1'b0; acc_last = 1'b0;
            d1 = digest_data[0];
            reload_mid = 1'b1; tick("mid_reload");
            reload_mid = 1'b0;
            check_val("mid_reload_blk", DW'(blk_cnt[0]), DW'(1));
            acc_valid = 1'b1; acc_data = blk2; acc_last = 1'b1;
            tick("mid_b2_again");
            acc_valid = 1'b0; acc_last = 1'b0;
            check_val("mid_same_digest", digest_data[0], d1);
            check_val("mid_blk2", DW'(blk_cnt[0]), DW'(2));
        end
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            init         = ($urandom_range(15) == 0);
            acc_valid    = 1'($urandom_range(1));
            acc_last     = ($urandom_range(3) == 0);
            digest_ready = ($urandom_range(2) == 0);
            acc_data     = rand_data();
`ifdef MIDSTATE_EN
            reload_mid   = ($urandom_range(15) == 0);
`endif
            tick("rand");
        end
        init = 1'b0; acc_valid = 1'b0; acc_last = 1'b0; digest_ready = 1'b0;
`ifdef MIDSTATE_EN
        reload_mid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
